// File: rtl/wave_env_adsr.sv
// rtl/wave_env_adsr.sv - ADSR envelope generator with two-stage waveform volume scaling.
module wave_env_adsr #(
    parameter int C_DAT_W = 12,
    parameter int C_ACC_W = 16
) (
    input  logic               CK_i,
    input  logic               RST_i,
    input  logic               EN_CK_i,
    input  logic               TICK_i,
    input  logic               GATE_i,
    input  logic [7:0]         ATTACK_i,
    input  logic [7:0]         DECAY_i,
    input  logic [7:0]         SUSTAIN_i,
    input  logic [7:0]         RELEASE_i,
    input  logic [C_DAT_W-1:0] WAVE_i,
    output logic [C_DAT_W-1:0] WAVE_o,
    output logic [7:0]         ENV_o,
    output logic [2:0]         STATE_o,
    output logic               BUSY_o
);

    localparam int C_P_W = C_DAT_W + 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [C_ACC_W-1:0]        acc_q, acc_d;
    logic                      gate_dly_q, gate_dly_d;
    logic signed [C_P_W-1:0]   prod_q, prod_d;
    logic [C_DAT_W-1:0]        wave_q, wave_d;

    logic [8:0]                att_step, dec_step, rel_step;
    logic [C_ACC_W-1:0]        target;
    logic [C_ACC_W:0]          att_sum, dec_floor;
    logic                      gate_rise;
    logic                      gate_released;

    logic [7:0]                env;
    logic signed [C_DAT_W-1:0] s_val;
    logic [8:0]                g_val;
    logic signed [C_P_W-1:0]   s_ext, g_ext;
    logic [C_DAT_W-1:0]        r_val;
    logic                      unused_prod_bits;

    assign env = acc_q[C_ACC_W-1 -: 8];

    always_comb begin
        att_step      = {1'b0, ATTACK_i} + 9'd1;
        dec_step      = {1'b0, DECAY_i} + 9'd1;
        rel_step      = {1'b0, RELEASE_i} + 9'd1;
        target        = {SUSTAIN_i, {(C_ACC_W-8){1'b0}}};
        // One extra bit so neither the attack ceiling nor the decay floor can wrap.
        att_sum       = {1'b0, acc_q} + {{(C_ACC_W-8){1'b0}}, att_step};
        dec_floor     = {1'b0, target} + {{(C_ACC_W-8){1'b0}}, dec_step};
        gate_rise     = GATE_i & ~gate_dly_q;
        gate_released = ~GATE_i && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                    state_q == ST_SUSTAIN);
    end

    always_comb begin
        s_val = {~WAVE_i[C_DAT_W-1], WAVE_i[C_DAT_W-2:0]};
        g_val = (env == 8'hFF) ? 9'd256 : {1'b0, env};
        s_ext = {{(C_P_W-C_DAT_W){s_val[C_DAT_W-1]}}, s_val};
        g_ext = {{(C_P_W-9){1'b0}}, g_val};
        // Bits [C_DAT_W+7:8] of the product are the floor of p/256, already in range.
        r_val = prod_q[C_DAT_W+7:8];
    end

    assign unused_prod_bits = ^{prod_q[C_P_W-1], prod_q[7:0]};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        gate_dly_d = gate_dly_q;
        prod_d     = prod_q;
        wave_d     = wave_q;
        if (EN_CK_i) begin
            gate_dly_d = GATE_i;
            prod_d     = s_ext * g_ext;
            wave_d     = {~r_val[C_DAT_W-1], r_val[C_DAT_W-2:0]};
            // Gate transitions take priority over a coincident tick; ACC holds.
            if (gate_rise) begin
                state_d = ST_ATTACK;
            end else if (gate_released) begin
                state_d = ST_RELEASE;
            end else if (TICK_i) begin
                case (state_q)
                    ST_ATTACK: begin
                        if (att_sum >= {1'b0, {C_ACC_W{1'b1}}}) begin
                            acc_d   = {C_ACC_W{1'b1}};
                            state_d = ST_DECAY;
                        end else begin
                            acc_d = att_sum[C_ACC_W-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if ({1'b0, acc_q} <= dec_floor) begin
                            acc_d   = target;
                            state_d = ST_SUSTAIN;
                        end else begin
                            acc_d = acc_q - {{(C_ACC_W-9){1'b0}}, dec_step};
                        end
                    end
                    ST_SUSTAIN: begin
                        acc_d = target;
                    end
                    ST_RELEASE: begin
                        if (acc_q <= {{(C_ACC_W-9){1'b0}}, rel_step}) begin
                            acc_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            acc_d = acc_q - {{(C_ACC_W-9){1'b0}}, rel_step};
                        end
                    end
                    default: begin
                        acc_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            gate_dly_q <= 1'b0;
            prod_q     <= '0;
            wave_q     <= {1'b1, {(C_DAT_W-1){1'b0}}};
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            gate_dly_q <= gate_dly_d;
            prod_q     <= prod_d;
            wave_q     <= wave_d;
        end
    end

    assign WAVE_o  = wave_q;
    assign ENV_o   = env;
    assign STATE_o = state_q;
    assign BUSY_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wave_env_adsr.sv
// tb/tb_wave_env_adsr.sv - Directed bench for wave_env_adsr with envelope model and wave scoreboard.
module tb_wave_env_adsr;

    logic        clk = 1'b0;
    logic        rst, en_ck, tick, gate;
    logic [7:0]  att, dec, sus, rel;
    logic [11:0] wave_in, wave_out;
    logic [7:0]  env;
    logic [2:0]  st;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    int          m_acc, m_st;
    bit          m_gd;
    logic [11:0] sb_q[$];
    logic [11:0] last_wave;

    wave_env_adsr dut (
        .CK_i      (clk),
        .RST_i     (rst),
        .EN_CK_i   (en_ck),
        .TICK_i    (tick),
        .GATE_i    (gate),
        .ATTACK_i  (att),
        .DECAY_i   (dec),
        .SUSTAIN_i (sus),
        .RELEASE_i (rel),
        .WAVE_i    (wave_in),
        .WAVE_o    (wave_out),
        .ENV_o     (env),
        .STATE_o   (st),
        .BUSY_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] scale_ref(input logic [11:0] w, input int e);
        int s, g, p, r;
        s = int'(w) - 2048;
        g = (e == 255) ? 256 : e;
        p = s * g;
        r = p >>> 8;
        return 12'(r + 2048);
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst_wave", wave_out, 12'h800);
            chk("rst_env", env, 0);
            chk("rst_state", st, 0);
            chk("rst_busy", busy, 0);
        end
        m_acc = 0; m_st = 0; m_gd = 1'b0;
        sb_q.delete();
        sb_q.push_back(12'h800);
        last_wave = 12'h800;
        rst = 1'b0;
    endtask

    task automatic cyc(input bit en, input bit tk);
        int step;
        en_ck = en;
        tick  = tk;
        if (en) begin
            sb_q.push_back(scale_ref(wave_in, m_acc >> 8));
            if (gate && !m_gd) begin
                m_st = 1;
            end else if (!gate && m_st >= 1 && m_st <= 3) begin
                m_st = 4;
            end else if (tk) begin
                case (m_st)
                    1: begin
                        step = int'(att) + 1;
                        if (m_acc + step >= 65535) begin m_acc = 65535; m_st = 2; end
                        else m_acc = m_acc + step;
                    end
                    2: begin
                        step = int'(dec) + 1;
                        if (m_acc - step <= int'(sus) * 256) begin m_acc = int'(sus) * 256; m_st = 3; end
                        else m_acc = m_acc - step;
                    end
                    3: m_acc = int'(sus) * 256;
                    4: begin
                        step = int'(rel) + 1;
                        if (m_acc <= step) begin m_acc = 0; m_st = 0; end
                        else m_acc = m_acc - step;
                    end
                    default: m_acc = 0;
                endcase
            end
            m_gd = gate;
        end
        @(posedge clk); #1;
        if (en) begin
            if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
            else last_wave = sb_q.pop_front();
        end
        chk("wave", wave_out, last_wave);
        chk("env", env, m_acc >> 8);
        chk("state", st, m_st);
        chk("busy", busy, m_st != 0);
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            cyc(1'b1, 1'b1);
            repeat (gap) cyc(1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; en_ck = 1'b0; tick = 1'b0; gate = 1'b1; wave_in = 12'hFFF;
        att = 8'hFF; dec = 8'hFF; sus = 8'h80; rel = 8'hFF;
        do_reset(1);
        en_ck = 1'b1; tick = 1'b1;
        do_reset(2);

        gate = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);

        // Attack from zero at maximum rate
        gate = 1'b1;
        cyc(1'b1, 1'b0);
        chk("attack_entry", st, 1);
        ticks(255, 3);
        chk("attack_255_env", env, 8'hFF);
        chk("attack_255_state", st, 1);
        cyc(1'b1, 1'b1);
        chk("attack_256_env", env, 8'hFF);
        chk("attack_256_state", st, 2);
        repeat (2) cyc(1'b1, 1'b0);
        chk("scale_fff_ff", wave_out, 12'hFFF);

        // Decay to sustain 0x80
        ticks(127, 3);
        chk("decay_127_state", st, 2);
        cyc(1'b1, 1'b1);
        chk("decay_128_state", st, 3);
        chk("decay_128_env", env, 8'h80);
        ticks(3, 1);
        chk("sustain_env", env, 8'h80);
        repeat (2) cyc(1'b1, 1'b0);
        chk("scale_fff_80", wave_out, 12'hBFF);
        wave_in = 12'h000;
        repeat (2) cyc(1'b1, 1'b0);
        chk("scale_000_80", wave_out, 12'h400);

        // Release to idle
        gate = 1'b0;
        cyc(1'b1, 1'b0);
        chk("release_entry", st, 4);
        ticks(127, 1);
        chk("release_127_env", env, 8'h01);
        cyc(1'b1, 1'b1);
        chk("release_128_env", env, 0);
        chk("release_128_state", st, 0);
        chk("release_128_busy", busy, 0);
        repeat (2) cyc(1'b1, 1'b0);
        chk("scale_000_00", wave_out, 12'h800);
        wave_in = 12'h5A3;
        repeat (2) cyc(1'b1, 1'b0);
        chk("scale_5a3_00", wave_out, 12'h800);

        // Second envelope, released to 0x4000 and retriggered
        wave_in = 12'h9C4;
        gate = 1'b1;
        cyc(1'b1, 1'b0);
        ticks(256, 1);
        chk("att2_state", st, 2);
        ticks(128, 1);
        chk("dec2_state", st, 3);
        gate = 1'b0;
        cyc(1'b1, 1'b0);
        ticks(64, 1);
        chk("rel2_env", env, 8'h40);
        chk("rel2_state", st, 4);
        gate = 1'b1;
        cyc(1'b1, 1'b1);
        chk("retrig_state", st, 1);
        chk("retrig_collide_env", env, 8'h40);
        cyc(1'b1, 1'b1);
        chk("retrig_resume_env", env, 8'h41);
        gate = 1'b0;
        cyc(1'b1, 1'b1);
        chk("fall_collide_state", st, 4);
        chk("fall_collide_env", env, 8'h41);

        // Clock enable low freezes everything
        for (int i = 0; i < 10; i++) begin
            gate = i[0];
            wave_in = 12'($urandom);
            cyc(1'b0, 1'b1);
        end
        chk("freeze_state", st, 4);
        chk("freeze_env", env, 8'h41);
        gate = 1'b0;
        cyc(1'b1, 1'b1);
        chk("unfreeze_env", env, 8'h40);

        // Reset mid-envelope
        do_reset(1);
        ticks(2, 0);
        chk("post_rst_state", st, 0);
        chk("post_rst_env", env, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
